mult6_sched: RTL and testbench

Round-robin scheduler sharing a single 6-bit unsigned multiplier core among `NREQ` requesters. Each requester uses a valid/ready handshake. The block arbitrates, launches one multiply at a time, and returns the 12-bit product tagged with the requester index through a single-entry output register. It sits between the client ports and the multiplier datapath, and is the only instance that drives the core's operands.

---
 rtl/mult6_sched_pkg.sv | 17 +
 rtl/mult6_core.sv | 32 +++
 rtl/mult6_sched.sv | 143 ++++++++++++++
 tb/tb_mult6_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult6_sched_pkg.sv
// Shared widths, operand/product types and scheduler state encoding for mult6_sched.
// The optional MULT6_SCHED_PIPE_EN build makes use of the CALC state.
package mult6_sched_pkg;

    localparam int OPW   = 6;
    localparam int PRODW = 12;

    typedef logic [OPW-1:0]   opnd_t;
    typedef logic [PRODW-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mult6_core.sv
// Purely combinational 6x6 unsigned multiplier: six partial products folded by
// a carry-save tree into two rows, then one carry-propagate add.
module mult6_core
    import mult6_sched_pkg::*;
(
    input  opnd_t a,
    input  opnd_t b,
    output prod_t p
);

    prod_t pp [OPW];
    prod_t s0, c0, s1, c1, s2, c2, s3, c3;

    // 3:2 compressor across a whole row; s + c always equals x + y + z.
    function automatic void csa(input prod_t x, input prod_t y, input prod_t z,
                                output prod_t s, output prod_t c);
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    always_comb begin
        for (int i = 0; i < OPW; i++) begin
            pp[i] = b[i] ? (prod_t'(a) << i) : '0;
        end
        csa(pp[0], pp[1], pp[2], s0, c0);
        csa(pp[3], pp[4], pp[5], s1, c1);
        csa(s0, c0, s1, s2, c2);
        csa(s2, c2, c1, s3, c3);
        p = s3 + c3;
    end

endmodule

// File: rtl/mult6_sched.sv
// Round-robin scheduler sharing one mult6_core among NREQ requesters.
// Define MULT6_SCHED_PIPE_EN to register operands/ID ahead of the core (adds CALC).
module mult6_sched
    import mult6_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*6-1:0]   req_a,
    input  logic [NREQ*6-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [11:0]         rsp_prod,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RESP = RESP;
`ifdef MULT6_SCHED_PIPE_EN
    localparam logic [1:0] ST_CALC = CALC;
`endif

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic [IDW:0]   scan;
    logic           found;
    logic           can_accept;
    logic           accept;
    opnd_t          sel_a, sel_b;
    opnd_t          core_a, core_b;
    prod_t          core_p;

`ifdef MULT6_SCHED_PIPE_EN
    opnd_t          a_q, b_q;
    logic [IDW-1:0] id_q;
`endif

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDW + 1)'(i);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = scan[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    assign accept     = can_accept && found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (gnt == IDW'(i));
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

`ifdef MULT6_SCHED_PIPE_EN
    assign core_a = a_q;
    assign core_b = b_q;
`else
    assign core_a = sel_a;
    assign core_b = sel_b;
`endif

    mult6_core u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // Output register only changes on a launch, so a stalled response stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            rsp_prod <= '0;
            rsp_id   <= '0;
`ifdef MULT6_SCHED_PIPE_EN
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
`endif
        end else begin
            if (accept) begin
                rr_ptr <= (gnt == LAST_IDX) ? '0 : gnt + IDW'(1);
            end
`ifdef MULT6_SCHED_PIPE_EN
            if (accept) begin
                state <= ST_CALC;
                a_q   <= sel_a;
                b_q   <= sel_b;
                id_q  <= gnt;
            end else if (state == ST_CALC) begin
                state    <= ST_RESP;
                rsp_prod <= core_p;
                rsp_id   <= id_q;
            end else if ((state == ST_RESP) && rsp_ready) begin
                state <= ST_IDLE;
            end
`else
            if (accept) begin
                state    <= ST_RESP;
                rsp_prod <= core_p;
                rsp_id   <= gnt;
            end else if ((state == ST_RESP) && rsp_ready) begin
                state <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mult6_sched.sv
// Scoreboard bench for mult6_sched (default build, MULT6_SCHED_PIPE_EN undefined):
// the driver queues hand-computed responses, a negedge monitor pops and compares.
module tb_mult6_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*6-1:0] req_a;
    logic [NREQ*6-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [11:0]       rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    typedef struct packed {
        logic [11:0]    prod;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mult6_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one requester; the expected response is queued in the order it should be served.
    task automatic applyStimulus(input int id, input int a, input int b, input bit expect_rsp);
        exp_t e;
        req_valid[id]     = 1'b1;
        req_a[id*6 +: 6]  = 6'(a);
        req_b[id*6 +: 6]  = 6'(b);
        if (expect_rsp) begin
            e.prod = 12'(a * b);
            e.id   = IDW'(id);
            sbq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got prod %0d id %0d, expected no response", rsp_prod, rsp_id);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("rsp_prod", 32'(rsp_prod), 32'(mon_e.prod));
                checkOutput("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_prod", 32'(rsp_prod), 0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 0);
        checkOutput("reset_req_ready", 32'(req_ready), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;

        $display("[TB] single request 5*10 from requester 0");
        rsp_ready = 1'b1;
        applyStimulus(0, 5, 10, 1);
        @(negedge clk);
        checkOutput("t1_grant", 32'(req_ready), 1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("t1_latency_valid", 32'(rsp_valid), 1);
        checkOutput("t1_busy", 32'(busy), 1);
        tick();
        @(negedge clk);
        checkOutput("t1_busy_after", 32'(busy), 0);
        checkOutput("t1_valid_after", 32'(rsp_valid), 0);

        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("[TB] four requesters, round-robin order");
        applyStimulus(0, 10, 27, 1);
        applyStimulus(1, 11, 21, 1);
        applyStimulus(2, 37, 63, 1);
        applyStimulus(3, 27, 46, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
            if (k == 3) begin
                applyStimulus(0, 10, 27, 1);
                applyStimulus(1, 11, 21, 1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_regrant%0d", k), 32'(req_ready), 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
        end
        @(negedge clk);
        tick();

        $display("[TB] backpressure on 63*63, then zero operand");
        rsp_ready = 1'b0;
        applyStimulus(2, 63, 63, 1);
        @(negedge clk);
        checkOutput("t3_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        applyStimulus(0, 0, 63, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t3_hold_prod", 32'(rsp_prod), 3969);
            checkOutput("t3_hold_id", 32'(rsp_id), 2);
            checkOutput("t3_hold_ready", 32'(req_ready), 0);
            checkOutput("t3_hold_valid", 32'(rsp_valid), 1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_accept_on_release", 32'(req_ready), 1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        tick();

        $display("[TB] back-to-back from requester 2");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, i + 1, 3, 1);
            @(negedge clk);
            checkOutput($sformatf("t4_grant%0d", i), 32'(req_ready), 32'b0100);
            if (i > 0) begin
                checkOutput($sformatf("t4_no_bubble%0d", i), 32'(rsp_valid), 1);
            end
            tick();
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("t4_last_valid", 32'(rsp_valid), 1);
        tick();

        $display("[TB] reset after accepting 27*46");
        applyStimulus(3, 27, 46, 0);
        @(negedge clk);
        checkOutput("t5_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("t5_rst_valid", 32'(rsp_valid), 0);
            checkOutput("t5_rst_busy", 32'(busy), 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1, 7, 9, 1);
        applyStimulus(3, 62, 2, 1);
        @(negedge clk);
        checkOutput("t5_first_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("t5_second_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("drain_queue", 32'(sbq.size()), 0);
        checkOutput("final_busy", 32'(busy), 0);
        checkOutput("final_valid", 32'(rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
